vga_text_ctrl: RTL

- Parametrised colour text-mode pixel pipeline; successor to the monochrome 8x8 text controller.
- Sits between the VGA timing generator (disp/x_pos/y_pos/hsync/vsync) and the text buffer and font ROM.
- Fetches a 16-bit cell per pixel: 8-bit code, 4-bit fg and 4-bit bg palette indices. Drives 4:4:4 RGB.
- Adds a blinking underline cursor and per-character blink; syncs are delayed to stay aligned with pixels.

---
 rtl/vga_text_pkg.sv | 29 ++
 rtl/vga_text_palette.sv | 13 +
 rtl/vga_text_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/vga_text_pkg.sv
// vga_text_pkg: shared definitions for the colour text-mode pixel pipeline.
//   - text cell field offsets (code / foreground / background)
//   - rgb444_t pixel type and the fixed 16-entry CGA palette
//   - pipeline latency LAT and the blink FSM state type
package vga_text_pkg;

    localparam int LAT = 3;

    localparam int CODE_LSB = 0;
    localparam int CODE_MSB = 7;
    localparam int FG_LSB   = 8;
    localparam int FG_MSB   = 11;
    localparam int BG_LSB   = 12;
    localparam int BG_MSB   = 15;

    // {R, G, B} nibbles
    typedef logic [11:0] rgb444_t;

    localparam rgb444_t CGA_PALETTE [16] = '{
        12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
        12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
    };

    typedef enum logic {
        BLINK_HIDE = 1'b0,
        BLINK_SHOW = 1'b1
    } blink_state_t;

endpackage

// File: rtl/vga_text_palette.sv
// vga_text_palette: combinational 16-entry palette lookup.
//   idx : 4-bit palette index
//   rgb : 12-bit {R,G,B} colour
module vga_text_palette
    import vga_text_pkg::*;
(
    input  logic [3:0]  idx,
    output logic [11:0] rgb
);

    assign rgb = CGA_PALETTE[idx];

endmodule

// File: rtl/vga_text_ctrl.sv
// vga_text_ctrl: colour text-mode pixel pipeline with blinking underline
// cursor, sitting between the VGA timing generator and the text buffer /
// font ROM.
//
// Ports:
//   clk, reset                 pixel clock, synchronous active-low reset
//   disp, x_pos, y_pos         timing generator: active area and position
//   hsync_in, vsync_in         timing generator syncs
//   frame_start                one-cycle pulse per frame (drives blink)
//   cell_addr / cell_data      text buffer address out, 16-bit cell in
//   font_addr / font_data      font ROM {code,row} out, glyph row in (bit0 = left)
//   cursor_en/col/row          underline cursor control
//   vga_r/g/b, hsync, vsync    4:4:4 colour and syncs, all LAT cycles behind input
//
// Build option: define VGA_TEXT_CHAR_BLINK_EN to make bg[3] a per-character
// blink attribute (background index becomes {0,bg[2:0]}, glyph hidden while
// the blink phase is HIDE). Without it bg is a full 4-bit index.
//
// Pipeline (input sampled at edge n):
//   n   : cell_addr, pixel column/row within glyph, cursor hit, disp, syncs
//   n+1 : font_addr, fg/bg from cell_data
//   n+2 : pixel bit from font_data, cursor / blink modifiers
//   n+3 : palette lookup into RGB
module vga_text_ctrl
    import vga_text_pkg::*;
#(
    parameter int H_DISP       = 1280,
    parameter int V_DISP       = 1024,
    parameter int FONT_W       = 8,
    parameter int FONT_H       = 16,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic                                              disp,
    input  logic [$clog2(H_DISP)-1:0]                         x_pos,
    input  logic [$clog2(V_DISP)-1:0]                         y_pos,
    input  logic                                              hsync_in,
    input  logic                                              vsync_in,
    input  logic                                              frame_start,
    output logic [$clog2((H_DISP/FONT_W)*(V_DISP/FONT_H))-1:0] cell_addr,
    input  logic [15:0]                                       cell_data,
    output logic [8+$clog2(FONT_H)-1:0]                       font_addr,
    input  logic [FONT_W-1:0]                                 font_data,
    input  logic                                              cursor_en,
    input  logic [$clog2(H_DISP/FONT_W)-1:0]                  cursor_col,
    input  logic [$clog2(V_DISP/FONT_H)-1:0]                  cursor_row,
    output logic [3:0]                                        vga_r,
    output logic [3:0]                                        vga_g,
    output logic [3:0]                                        vga_b,
    output logic                                              hsync,
    output logic                                              vsync
);

    localparam int COLS = H_DISP / FONT_W;
    localparam int ROWS = V_DISP / FONT_H;
    localparam int CW   = $clog2(FONT_W);
    localparam int RW   = $clog2(FONT_H);
    localparam int CAW  = $clog2(COLS * ROWS);
    localparam int CCW  = $clog2(COLS);
    localparam int CRW  = $clog2(ROWS);
    localparam int BCW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    if ((H_DISP % FONT_W) != 0 || (V_DISP % FONT_H) != 0) begin : g_bad_geometry
        $error("vga_text_ctrl: display size must be a multiple of the glyph size");
    end

    // ---------------- blink FSM ----------------
    blink_state_t   blink_state;
    logic [BCW-1:0] blink_cnt;
    logic           blink_phase;

    always_ff @(posedge clk) begin
        if (!reset) begin
            blink_state <= BLINK_SHOW;
            blink_cnt   <= '0;
        end else if (frame_start) begin
            if (blink_cnt == BCW'(BLINK_FRAMES - 1)) begin
                blink_cnt   <= '0;
                blink_state <= (blink_state == BLINK_SHOW) ? BLINK_HIDE : BLINK_SHOW;
            end else begin
                blink_cnt <= blink_cnt + BCW'(1);
            end
        end
    end

    assign blink_phase = (blink_state == BLINK_SHOW);

    // ---------------- S0 combinational ----------------
    // Glyph sizes are powers of two, so cell coordinates are plain shifts.
    logic [CCW-1:0] cell_col;
    logic [CRW-1:0] cell_row;
    logic           cursor_hit;

    assign cell_col   = CCW'(x_pos >> CW);
    assign cell_row   = CRW'(y_pos >> RW);
    // Underline occupies the bottom two glyph rows of the cursor cell.
    assign cursor_hit = cursor_en && (cell_col == cursor_col) && (cell_row == cursor_row)
                        && (y_pos[RW-1:0] >= RW'(FONT_H - 2));

    // ---------------- pipeline registers ----------------
    logic [LAT-1:0] vld_pipe;          // disp delayed, [k] valid after edge n+k
    logic [LAT:0]   hs_pipe, vs_pipe;  // [LAT] is the output register
    logic [CW-1:0]  col_s0, col_s1;
    logic [RW-1:0]  row_s0;
    logic           hit_s0, hit_s1;
    logic [3:0]     fg_s1, bg_s1, fg_s2, bg_s2;
    logic           pix_s2;
    logic [11:0]    rgb_q;

    // ---------------- S2 combinational ----------------
    logic       pix_c;
    logic [3:0] bg_idx_c;

    always_comb begin
        pix_c    = font_data[col_s1];
        bg_idx_c = bg_s1;
        if (hit_s1 && blink_phase)
            pix_c = ~pix_c;
`ifdef VGA_TEXT_CHAR_BLINK_EN
        bg_idx_c = {1'b0, bg_s1[2:0]};
        if (bg_s1[3] && !blink_phase)
            pix_c = 1'b0;
`endif
    end

    // ---------------- S3 palette ----------------
    logic [3:0]  pal_idx;
    logic [11:0] pal_rgb;

    assign pal_idx = pix_s2 ? fg_s2 : bg_s2;

    vga_text_palette u_palette (
        .idx (pal_idx),
        .rgb (pal_rgb)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            cell_addr <= '0;
            font_addr <= '0;
            vld_pipe  <= '0;
            hs_pipe   <= '1;
            vs_pipe   <= '1;
            col_s0    <= '0;
            col_s1    <= '0;
            row_s0    <= '0;
            hit_s0    <= 1'b0;
            hit_s1    <= 1'b0;
            fg_s1     <= '0;
            bg_s1     <= '0;
            fg_s2     <= '0;
            bg_s2     <= '0;
            pix_s2    <= 1'b0;
            rgb_q     <= '0;
        end else begin
            // S0
            cell_addr <= CAW'(cell_row) * CAW'(COLS) + CAW'(cell_col);
            col_s0    <= x_pos[CW-1:0];
            row_s0    <= y_pos[RW-1:0];
            hit_s0    <= cursor_hit;
            vld_pipe  <= {vld_pipe[LAT-2:0], disp};
            hs_pipe   <= {hs_pipe[LAT-1:0], hsync_in};
            vs_pipe   <= {vs_pipe[LAT-1:0], vsync_in};
            // S1
            font_addr <= {cell_data[CODE_MSB:CODE_LSB], row_s0};
            fg_s1     <= cell_data[FG_MSB:FG_LSB];
            bg_s1     <= cell_data[BG_MSB:BG_LSB];
            col_s1    <= col_s0;
            hit_s1    <= hit_s0;
            // S2
            pix_s2    <= pix_c;
            fg_s2     <= fg_s1;
            bg_s2     <= bg_idx_c;
            // S3
            rgb_q     <= vld_pipe[LAT-1] ? pal_rgb : 12'h000;
        end
    end

    assign vga_r = rgb_q[11:8];
    assign vga_g = rgb_q[7:4];
    assign vga_b = rgb_q[3:0];
    assign hsync = hs_pipe[LAT];
    assign vsync = vs_pipe[LAT];

endmodule
